// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory with byte/halfword/word access,
// optional wait states before each OKAY data phase and a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [2:0]            hsize,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic                  hready,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic [1:0]            hresp,
    output logic                  hready_resp
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH * 4);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            lo_q, lo_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [3:0]            fwd_be_q, fwd_be_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

    logic                  trans_valid;
    logic                  accept;
    logic                  addr_err;
    logic                  commit;
    logic [3:0]            be;
    logic [IDX_W-1:0]      haddr_idx;
    logic [DATA_WIDTH-1:0] merged_word;

    assign hready_resp = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign hresp       = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
    assign hrdata      = (state_q == ST_DATA) ? merged_word : '0;

    assign trans_valid = (htrans == 2'b10) || (htrans == 2'b11);
    assign accept      = hsel && hready && trans_valid && hready_resp;
    assign haddr_idx   = haddr[IDX_W+1:2];

    assign addr_err = (hsize > 3'd2)
                   || ((hsize == 3'd1) && haddr[0])
                   || ((hsize == 3'd2) && (haddr[1:0] != 2'b00))
                   || ({1'b0, haddr} >= ADDR_LIMIT);

    // A reset in the data phase discards the transfer, so it must also block the commit.
    assign commit = (state_q == ST_DATA) && write_q && !hreset;

    always_comb begin
        be = 4'b0000;
        case (size_q)
            2'd0:    be = 4'b0001 << lo_q;
            2'd1:    be = lo_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        size_d     = size_q;
        lo_d       = lo_q;
        idx_d      = idx_q;
        fwd_be_d   = fwd_be_q;
        fwd_data_d = fwd_data_q;

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            write_d = hwrite;
            size_d  = hsize[1:0];
            lo_d    = haddr[1:0];
            idx_d   = haddr_idx;
            // The RAM read issued now sees the old word if a write to it commits on this edge.
            fwd_be_d   = (commit && (idx_q == haddr_idx)) ? be : 4'b0000;
            fwd_data_d = hwdata;
            if (addr_err) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES == 0) begin
                state_d = ST_DATA;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_LOAD;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            write_q    <= 1'b0;
            size_q     <= 2'd0;
            lo_q       <= 2'd0;
            idx_q      <= '0;
            fwd_be_q   <= 4'b0000;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            size_q     <= size_d;
            lo_q       <= lo_d;
            idx_q      <= idx_d;
            fwd_be_q   <= fwd_be_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // One byte-wide RAM per lane so byte enables map onto plain write enables.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_lane_q;

            always_ff @(posedge hclk) begin
                if (commit && be[gi]) begin
                    mem[idx_q] <= hwdata[8*gi +: 8];
                end
                if (accept) begin
                    rd_lane_q <= mem[haddr_idx];
                end
            end

            assign merged_word[8*gi +: 8] = fwd_be_q[gi] ? fwd_data_q[8*gi +: 8] : rd_lane_q;
        end
    endgenerate

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with no wait states, one with three.
module tb_ahb_sram_slave;

    localparam logic [1:0] ID = 2'd0;
    localparam logic [1:0] BZ = 2'd1;
    localparam logic [1:0] NS = 2'd2;

    typedef struct {
        logic        sel;
        logic        rin;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [19:0] a;
        logic [31:0] wd;
        logic        exp_rdy;
        logic [1:0]  exp_resp;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    logic        hclk = 1'b0;
    logic        hreset0, hreset1;
    logic        hsel0, hsel1;
    logic [19:0] haddr;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    logic        hready;
    logic [31:0] hwdata;
    logic [31:0] hrdata0, hrdata1;
    logic [1:0]  hresp0, hresp1;
    logic        hready_resp0, hready_resp1;

    int checks   = 0;
    int failures = 0;

    always #5 hclk = ~hclk;

    ahb_sram_slave #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hreset(hreset0), .hsel(hsel0), .haddr(haddr), .hsize(hsize),
        .htrans(htrans), .hwrite(hwrite), .hready(hready), .hwdata(hwdata),
        .hrdata(hrdata0), .hresp(hresp0), .hready_resp(hready_resp0)
    );

    ahb_sram_slave #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
        .hclk(hclk), .hreset(hreset1), .hsel(hsel1), .haddr(haddr), .hsize(hsize),
        .htrans(htrans), .hwrite(hwrite), .hready(hready), .hwdata(hwdata),
        .hrdata(hrdata1), .hresp(hresp1), .hready_resp(hready_resp1)
    );

    function automatic vec_t mk(logic sel, logic rin, logic [1:0] tr, logic wr, logic [2:0] sz,
                                logic [19:0] a, logic [31:0] wd, logic er, logic [1:0] ep,
                                logic cr, logic [31:0] ed);
        vec_t v;
        v.sel = sel; v.rin = rin; v.tr = tr; v.wr = wr; v.sz = sz; v.a = a; v.wd = wd;
        v.exp_rdy = er; v.exp_resp = ep; v.chk_rd = cr; v.exp_rd = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic s0, input logic s1, input logic rin, input logic [1:0] tr,
                         input logic wr, input logic [2:0] sz, input logic [19:0] a,
                         input logic [31:0] wd);
        hsel0 = s0; hsel1 = s1; hready = rin; htrans = tr;
        hwrite = wr; hsize = sz; haddr = a; hwdata = wd;
    endtask

    task automatic apply(input vec_t v, input int which, input int n);
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rd;
        drive((which == 0) ? v.sel : 1'b0, (which == 1) ? v.sel : 1'b0,
              v.rin, v.tr, v.wr, v.sz, v.a, v.wd);
        @(posedge hclk); #1;
        rdy  = (which == 0) ? hready_resp0 : hready_resp1;
        resp = (which == 0) ? hresp0 : hresp1;
        rd   = (which == 0) ? hrdata0 : hrdata1;
        chk($sformatf("ws%0d_v%0d_ready", which * 3, n), {31'd0, rdy}, {31'd0, v.exp_rdy});
        chk($sformatf("ws%0d_v%0d_resp", which * 3, n), {30'd0, resp}, {30'd0, v.exp_resp});
        if (v.chk_rd) begin
            chk($sformatf("ws%0d_v%0d_rdata", which * 3, n), rd, v.exp_rd);
        end
        $display("ws%0d vec %0d: trans=%0d wr=%0d size=%0d addr=%h wdata=%h -> ready=%0d resp=%0d rdata=%h",
                 which * 3, n, v.tr, v.wr, v.sz, v.a, v.wd, rdy, resp, rd);
    endtask

    // Read on the three-wait-state instance and count the hready_resp-low cycles.
    task automatic read_wait1(input string name, input logic [19:0] a, input logic [31:0] exp);
        int lows;
        drive(1'b0, 1'b1, 1'b1, NS, 1'b0, 3'd2, a, 32'h0);
        @(posedge hclk); #1;
        drive(1'b0, 1'b0, 1'b1, ID, 1'b0, 3'd0, 20'h0, 32'h0);
        lows = 0;
        while (hready_resp1 == 1'b0 && lows < 20) begin
            lows++;
            @(posedge hclk); #1;
        end
        chk({name, "_lows"}, 32'(lows), 32'd3);
        chk({name, "_rdata"}, hrdata1, exp);
        chk({name, "_resp"}, {30'd0, hresp1}, 32'd0);
        $display("ws3 read %h: %0d wait cycles, rdata=%h resp=%0d", a, lows, hrdata1, hresp1);
        @(posedge hclk); #1;
    endtask

    vec_t tab0[$];
    vec_t tab1[$];

    initial begin
        // No wait states: word RAW, byte/halfword merge, errors, ignored transfers.
        tab0.push_back(mk(1, 1, NS, 1, 2, 20'h010, 32'h0,        1, 0, 0, 32'h0));
        tab0.push_back(mk(1, 1, NS, 0, 2, 20'h010, 32'hDEADBEEF, 1, 0, 1, 32'hDEADBEEF));
        tab0.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'h0,        1, 0, 1, 32'h0));
        tab0.push_back(mk(1, 1, NS, 1, 2, 20'h020, 32'h0,        1, 0, 0, 32'h0));
        tab0.push_back(mk(1, 1, NS, 1, 0, 20'h022, 32'h11223344, 1, 0, 1, 32'h11223344));
        tab0.push_back(mk(1, 1, NS, 1, 1, 20'h020, 32'h00AA0000, 1, 0, 1, 32'h11AA3344));
        tab0.push_back(mk(1, 1, NS, 0, 2, 20'h020, 32'h00005566, 1, 0, 1, 32'h11AA5566));
        tab0.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'h0,        1, 0, 1, 32'h0));
        tab0.push_back(mk(1, 1, NS, 0, 2, 20'h1000, 32'h0,       0, 1, 1, 32'h0));
        tab0.push_back(mk(1, 1, NS, 1, 2, 20'h010, 32'h0,        1, 1, 1, 32'h0));
        tab0.push_back(mk(1, 1, NS, 1, 1, 20'h021, 32'hFFFFFFFF, 0, 1, 1, 32'h0));
        tab0.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'hFFFFFFFF, 1, 1, 1, 32'h0));
        tab0.push_back(mk(1, 1, NS, 1, 3, 20'h010, 32'h0,        0, 1, 1, 32'h0));
        tab0.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'hFFFFFFFF, 1, 1, 1, 32'h0));
        tab0.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'h0,        1, 0, 1, 32'h0));
        tab0.push_back(mk(1, 1, ID, 1, 2, 20'h020, 32'hFFFFFFFF, 1, 0, 1, 32'h0));
        tab0.push_back(mk(1, 1, BZ, 1, 2, 20'h020, 32'hFFFFFFFF, 1, 0, 1, 32'h0));
        tab0.push_back(mk(0, 1, NS, 1, 2, 20'h020, 32'hFFFFFFFF, 1, 0, 1, 32'h0));
        tab0.push_back(mk(1, 0, NS, 1, 2, 20'h020, 32'hFFFFFFFF, 1, 0, 1, 32'h0));
        tab0.push_back(mk(1, 1, NS, 0, 2, 20'h010, 32'hFFFFFFFF, 1, 0, 1, 32'hDEADBEEF));
        tab0.push_back(mk(1, 1, NS, 0, 2, 20'h020, 32'h0,        1, 0, 1, 32'h11AA5566));
        tab0.push_back(mk(1, 1, NS, 0, 0, 20'h023, 32'h0,        1, 0, 1, 32'h11AA5566));
        tab0.push_back(mk(1, 1, NS, 0, 2, 20'hFFC, 32'h0,        1, 0, 0, 32'h0));
        tab0.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'h0,        1, 0, 1, 32'h0));

        // Three wait states: pipelined write/read @0x8, error timing, write @0x4.
        tab1.push_back(mk(1, 1, NS, 1, 2, 20'h008, 32'h0,        0, 0, 1, 32'h0));
        tab1.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'h12345678, 0, 0, 1, 32'h0));
        tab1.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'h12345678, 0, 0, 1, 32'h0));
        tab1.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'h12345678, 1, 0, 0, 32'h0));
        tab1.push_back(mk(1, 1, NS, 0, 2, 20'h008, 32'h12345678, 0, 0, 1, 32'h0));
        tab1.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'h0,        0, 0, 1, 32'h0));
        tab1.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'h0,        0, 0, 1, 32'h0));
        tab1.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'h0,        1, 0, 1, 32'h12345678));
        tab1.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'h0,        1, 0, 1, 32'h0));
        tab1.push_back(mk(1, 1, NS, 0, 2, 20'h1000, 32'h0,       0, 1, 1, 32'h0));
        tab1.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'h0,        1, 1, 1, 32'h0));
        tab1.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'h0,        1, 0, 1, 32'h0));
        tab1.push_back(mk(1, 1, NS, 1, 2, 20'h004, 32'h0,        0, 0, 1, 32'h0));
        tab1.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'hCAFEF00D, 0, 0, 1, 32'h0));
        tab1.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'hCAFEF00D, 0, 0, 1, 32'h0));
        tab1.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'hCAFEF00D, 1, 0, 0, 32'h0));
        tab1.push_back(mk(0, 1, ID, 0, 0, 20'h000, 32'hCAFEF00D, 1, 0, 1, 32'h0));

        hreset0 = 1'b1;
        hreset1 = 1'b1;
        drive(1'b0, 1'b0, 1'b1, ID, 1'b0, 3'd0, 20'h0, 32'h0);
        repeat (3) @(posedge hclk);
        #1;
        chk("rst_ws0_ready", {31'd0, hready_resp0}, 32'd1);
        chk("rst_ws0_resp",  {30'd0, hresp0}, 32'd0);
        chk("rst_ws0_rdata", hrdata0, 32'd0);
        chk("rst_ws3_ready", {31'd0, hready_resp1}, 32'd1);
        chk("rst_ws3_resp",  {30'd0, hresp1}, 32'd0);
        chk("rst_ws3_rdata", hrdata1, 32'd0);
        hreset0 = 1'b0;
        hreset1 = 1'b0;

        for (int i = 0; i < tab0.size(); i++) apply(tab0[i], 0, i);
        for (int i = 0; i < tab1.size(); i++) apply(tab1[i], 1, i);

        read_wait1("ws3_rd4", 20'h004, 32'hCAFEF00D);

        // Reset during the wait phase of a write must drop the write entirely.
        drive(1'b0, 1'b1, 1'b1, NS, 1'b1, 3'd2, 20'h004, 32'h0);
        @(posedge hclk); #1;
        chk("rstwait_in_wait", {31'd0, hready_resp1}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, ID, 1'b0, 3'd0, 20'h0, 32'hFFFFFFFF);
        hreset1 = 1'b1;
        @(posedge hclk); #1;
        hreset1 = 1'b0;
        chk("rstwait_ready", {31'd0, hready_resp1}, 32'd1);
        chk("rstwait_resp",  {30'd0, hresp1}, 32'd0);
        chk("rstwait_rdata", hrdata1, 32'd0);
        $display("ws3 reset in wait: ready=%0d resp=%0d rdata=%h", hready_resp1, hresp1, hrdata1);
        @(posedge hclk); #1;
        chk("rstwait_idle_ready", {31'd0, hready_resp1}, 32'd1);
        read_wait1("ws3_rd4_after_rst", 20'h004, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
